// File: rtl/ocx_dlx_tx_gb_ctl_pkg.sv
// Shared definitions for the DLX TX gearbox control slice.
// - state_t      : training FSM state encodings (encoding 7 unused)
// - SEQ_LAST     : last gearbox sequence value; the frame boundary
// - STALL_FIRST  : first sequence value of the two-cycle stall window
// - RESET_HOLD   : cycles spent in RESET after dlx_reset deasserts
// - SYNC_FRAMES  : number of whole frames the sync pattern is sent
package ocx_dlx_tx_gb_ctl_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_ZEROS = 3'd1,
    ST_PAT_A = 3'd2,
    ST_PAT_B = 3'd3,
    ST_SYNC  = 3'd4,
    ST_TRAIN = 3'd5,
    ST_DATA  = 3'd6
  } state_t;

  localparam logic [6:0] SEQ_LAST    = 7'd65;
  localparam logic [6:0] STALL_FIRST = 7'd64;
  localparam logic [1:0] RESET_HOLD  = 2'd2;
  localparam logic [1:0] SYNC_FRAMES = 2'd1;

endpackage

// File: rtl/ocx_dlx_tx_gb_seq_cnt.sv
// Gearbox sequence counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   hold       : force the counter to 0 (link in RESET)
//   seq        : sequence 0..SEQ_LAST, wraps to 0
//   stall      : high while seq is STALL_FIRST..SEQ_LAST
//   frame_end  : high while seq is SEQ_LAST (frame boundary cycle)
// All outputs are registered; stall/frame_end are decoded from the
// next sequence value so they line up with the registered seq.
module ocx_dlx_tx_gb_seq_cnt
  import ocx_dlx_tx_gb_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [6:0] seq,
  output logic       stall,
  output logic       frame_end
);

  logic [6:0] seq_d;

  always_comb begin
    seq_d = 7'd0;
    if (!hold) begin
      seq_d = (seq == SEQ_LAST) ? 7'd0 : seq + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq       <= 7'd0;
      stall     <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      seq       <= seq_d;
      stall     <= (seq_d >= STALL_FIRST);
      frame_end <= (seq_d == SEQ_LAST);
    end
  end

endmodule

// File: rtl/ocx_dlx_tx_gb_ctl.sv
// DLX TX gearbox training controller.
// Ports:
//   dlx_clk, dlx_reset         : clock, synchronous active-high reset
//   phy_ready                  : PHY TX path ready
//   rx_pattern_a_det/b_det     : RX saw pattern A / B
//   rx_trained                 : RX training complete
//   orx_otx_train_failed       : RX training failure (acts immediately)
//   cfg_timeout                : training timeout in frames, 0 = off
//   ctl_gb_seq, ctl_gb_stall   : gearbox sequence and TX queue hold
//   ctl_gb_*                   : gearbox mode controls
//   link_up                    : DATA state reached
//   train_state                : current FSM state encoding
//   train_timeout              : one-cycle pulse on training timeout
// Normal state advances only commit on the frame boundary cycle so a
// pattern block is never torn; reset and train_failed bypass that.
module ocx_dlx_tx_gb_ctl
  import ocx_dlx_tx_gb_ctl_pkg::*;
(
  input  logic        dlx_clk,
  input  logic        dlx_reset,
  input  logic        phy_ready,
  input  logic        rx_pattern_a_det,
  input  logic        rx_pattern_b_det,
  input  logic        rx_trained,
  input  logic        orx_otx_train_failed,
  input  logic [15:0] cfg_timeout,
  output logic [6:0]  ctl_gb_seq,
  output logic        ctl_gb_stall,
  output logic        ctl_gb_reset,
  output logic        ctl_gb_train,
  output logic        ctl_gb_tx_zeros,
  output logic        ctl_gb_tx_a_pattern,
  output logic        ctl_gb_tx_b_pattern,
  output logic        ctl_gb_tx_sync_pattern,
  output logic        link_up,
  output logic [2:0]  train_state,
  output logic        train_timeout
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic [1:0]  sync_cnt_q, sync_cnt_d;
  logic [1:0]  rst_cnt_q, rst_cnt_d;
  logic        to_fire;
  logic        timed;
  logic        frame_end;

  ocx_dlx_tx_gb_seq_cnt u_seq_cnt (
    .clk       (dlx_clk),
    .rst       (dlx_reset),
    .hold      (state_q == ST_RESET),
    .seq       (ctl_gb_seq),
    .stall     (ctl_gb_stall),
    .frame_end (frame_end)
  );

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    sync_cnt_d = sync_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    to_fire    = 1'b0;
    to_cnt_inc = sat_inc(to_cnt_q);
    timed      = (state_q == ST_PAT_A) || (state_q == ST_PAT_B) ||
                 (state_q == ST_TRAIN);

    // Normal advance (lowest priority)
    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RESET_HOLD - 2'd1) state_d = ST_ZEROS;
        else                                rst_cnt_d = rst_cnt_q + 2'd1;
      end
      ST_ZEROS: if (frame_end && phy_ready)        state_d = ST_PAT_A;
      ST_PAT_A: if (frame_end && rx_pattern_a_det) state_d = ST_PAT_B;
      ST_PAT_B: if (frame_end && rx_pattern_b_det) state_d = ST_SYNC;
      ST_SYNC: begin
        if (frame_end) begin
          if (sync_cnt_q == SYNC_FRAMES - 2'd1) state_d = ST_TRAIN;
          else                                  sync_cnt_d = sync_cnt_q + 2'd1;
        end
      end
      ST_TRAIN: if (frame_end && rx_trained) state_d = ST_DATA;
      ST_DATA:  state_d = ST_DATA;
      default:  state_d = ST_RESET;
    endcase

    // Timeout beats a normal advance at the same boundary
    if (timed && frame_end) begin
      if ((cfg_timeout != 16'd0) && (to_cnt_inc >= cfg_timeout)) begin
        state_d = ST_ZEROS;
        to_fire = 1'b1;
      end else begin
        to_cnt_d = to_cnt_inc;
      end
    end

    // Training failure beats everything except reset; unused encoding
    // is left to recover through RESET.
    if (orx_otx_train_failed && (state_q != ST_RESET) &&
        (state_q != state_t'(3'd7))) begin
      state_d = ST_ZEROS;
      to_fire = 1'b0;
    end

    if (state_d != state_q) begin
      to_cnt_d   = 16'd0;
      sync_cnt_d = 2'd0;
      rst_cnt_d  = 2'd0;
    end
  end

  always_ff @(posedge dlx_clk) begin
    if (dlx_reset) begin
      state_q                <= ST_RESET;
      to_cnt_q               <= 16'd0;
      sync_cnt_q             <= 2'd0;
      rst_cnt_q              <= 2'd0;
      ctl_gb_reset           <= 1'b1;
      ctl_gb_tx_zeros        <= 1'b1;
      ctl_gb_tx_a_pattern    <= 1'b0;
      ctl_gb_tx_b_pattern    <= 1'b0;
      ctl_gb_tx_sync_pattern <= 1'b0;
      ctl_gb_train           <= 1'b0;
      link_up                <= 1'b0;
      train_timeout          <= 1'b0;
    end else begin
      state_q                <= state_d;
      to_cnt_q               <= to_cnt_d;
      sync_cnt_q             <= sync_cnt_d;
      rst_cnt_q              <= rst_cnt_d;
      ctl_gb_reset           <= (state_d == ST_RESET);
      ctl_gb_tx_zeros        <= (state_d == ST_RESET) || (state_d == ST_ZEROS);
      ctl_gb_tx_a_pattern    <= (state_d == ST_PAT_A);
      ctl_gb_tx_b_pattern    <= (state_d == ST_PAT_B);
      ctl_gb_tx_sync_pattern <= (state_d == ST_SYNC);
      ctl_gb_train           <= (state_d == ST_TRAIN);
      link_up                <= (state_d == ST_DATA);
      train_timeout          <= to_fire;
    end
  end

  assign train_state = state_q;

endmodule

// File: tb/tb_ocx_dlx_tx_gb_ctl.sv
// Directed bench for the DLX TX gearbox training controller.
module tb_ocx_dlx_tx_gb_ctl;

  logic        clk;
  logic        dlx_reset;
  logic        phy_ready;
  logic        rx_pattern_a_det;
  logic        rx_pattern_b_det;
  logic        rx_trained;
  logic        orx_otx_train_failed;
  logic [15:0] cfg_timeout;
  logic [6:0]  ctl_gb_seq;
  logic        ctl_gb_stall;
  logic        ctl_gb_reset;
  logic        ctl_gb_train;
  logic        ctl_gb_tx_zeros;
  logic        ctl_gb_tx_a_pattern;
  logic        ctl_gb_tx_b_pattern;
  logic        ctl_gb_tx_sync_pattern;
  logic        link_up;
  logic [2:0]  train_state;
  logic        train_timeout;

  int total = 0;
  int bad   = 0;

  ocx_dlx_tx_gb_ctl dut (
    .dlx_clk                (clk),
    .dlx_reset              (dlx_reset),
    .phy_ready              (phy_ready),
    .rx_pattern_a_det       (rx_pattern_a_det),
    .rx_pattern_b_det       (rx_pattern_b_det),
    .rx_trained             (rx_trained),
    .orx_otx_train_failed   (orx_otx_train_failed),
    .cfg_timeout            (cfg_timeout),
    .ctl_gb_seq             (ctl_gb_seq),
    .ctl_gb_stall           (ctl_gb_stall),
    .ctl_gb_reset           (ctl_gb_reset),
    .ctl_gb_train           (ctl_gb_train),
    .ctl_gb_tx_zeros        (ctl_gb_tx_zeros),
    .ctl_gb_tx_a_pattern    (ctl_gb_tx_a_pattern),
    .ctl_gb_tx_b_pattern    (ctl_gb_tx_b_pattern),
    .ctl_gb_tx_sync_pattern (ctl_gb_tx_sync_pattern),
    .link_up                (link_up),
    .train_state            (train_state),
    .train_timeout          (train_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic wait_seq(input logic [6:0] v);
    int n = 0;
    while (ctl_gb_seq !== v && n < 200) begin
      tick();
      n++;
    end
    chkv("wait_seq", 16'(ctl_gb_seq), 16'(v));
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (train_state !== s && n < 1000) begin
      tick();
      n++;
    end
    chkv("wait_state", 16'(train_state), 16'(s));
  endtask

  task automatic chk_modes_excl(input string tag);
    int ones;
    ones = int'(ctl_gb_tx_zeros) + int'(ctl_gb_tx_a_pattern) + int'(ctl_gb_tx_b_pattern) +
           int'(ctl_gb_tx_sync_pattern) + int'(ctl_gb_train);
    chk1(tag, ones <= 1, 1'b1);
  endtask

  initial begin
    int sync_hi;
    int exp_seq;
    dlx_reset            = 1'b1;
    phy_ready            = 1'b1;
    rx_pattern_a_det     = 1'b0;
    rx_pattern_b_det     = 1'b0;
    rx_trained           = 1'b0;
    orx_otx_train_failed = 1'b0;
    cfg_timeout          = 16'd0;

    // Reset state
    tick();
    tick();
    chkv("rst_state", 16'(train_state), 16'd0);
    chkv("rst_seq", 16'(ctl_gb_seq), 16'd0);
    chk1("rst_stall", ctl_gb_stall, 1'b0);
    chk1("rst_gbreset", ctl_gb_reset, 1'b1);
    chk1("rst_zeros", ctl_gb_tx_zeros, 1'b1);
    chk1("rst_link", link_up, 1'b0);
    chk1("rst_to", train_timeout, 1'b0);
    chk1("rst_train", ctl_gb_train, 1'b0);

    // Scenario 1: release reset, two RESET cycles, then sequence/stall
    dlx_reset = 1'b0;
    chk1("rel_gbreset_c1", ctl_gb_reset, 1'b1);
    tick();
    chk1("rel_gbreset_c2", ctl_gb_reset, 1'b1);
    chkv("rel_state_c2", 16'(train_state), 16'd0);
    tick();
    chkv("zeros_state", 16'(train_state), 16'd1);
    chk1("zeros_gbreset", ctl_gb_reset, 1'b0);
    chk1("zeros_zeros", ctl_gb_tx_zeros, 1'b1);
    chkv("zeros_seq0", 16'(ctl_gb_seq), 16'd0);
    for (int i = 1; i < 132; i++) begin
      tick();
      exp_seq = i % 66;
      chkv("seq_run", 16'(ctl_gb_seq), 16'(exp_seq));
      chk1("stall_run", ctl_gb_stall, exp_seq >= 64);
      chkv("state_run", 16'(train_state), (i < 66) ? 16'd1 : 16'd2);
      chk_modes_excl("excl_run");
    end
    chk1("pata_mode", ctl_gb_tx_a_pattern, 1'b1);
    chk1("pata_zeros", ctl_gb_tx_zeros, 1'b0);

    // Scenario 2: bring-up with det inputs raised mid-frame
    wait_seq(7'd30);
    rx_pattern_a_det = 1'b1;
    wait_seq(7'd65);
    chkv("pata_hold_midframe", 16'(train_state), 16'd2);
    tick();
    chkv("patb_state", 16'(train_state), 16'd3);
    chkv("patb_seq", 16'(ctl_gb_seq), 16'd0);
    chk1("patb_mode", ctl_gb_tx_b_pattern, 1'b1);
    rx_pattern_a_det = 1'b0;
    wait_seq(7'd10);
    rx_pattern_b_det = 1'b1;
    wait_seq(7'd20);
    rx_pattern_b_det = 1'b0;
    wait_seq(7'd65);
    tick();
    chkv("patb_det_dropped", 16'(train_state), 16'd3);
    wait_seq(7'd50);
    rx_pattern_b_det = 1'b1;
    wait_seq(7'd65);
    chkv("patb_before_bnd", 16'(train_state), 16'd3);
    tick();
    rx_pattern_b_det = 1'b0;
    chkv("sync_state", 16'(train_state), 16'd4);
    sync_hi = 0;
    for (int i = 0; i < 70; i++) begin
      if (ctl_gb_tx_sync_pattern === 1'b1) sync_hi++;
      chk_modes_excl("excl_sync");
      tick();
    end
    chkv("sync_cycles", 16'(sync_hi), 16'd66);
    chkv("train_state", 16'(train_state), 16'd5);
    chkv("train_seq", 16'(ctl_gb_seq), 16'd4);
    chk1("train_mode", ctl_gb_train, 1'b1);
    wait_seq(7'd30);
    rx_trained = 1'b1;
    wait_seq(7'd65);
    chkv("train_before_bnd", 16'(train_state), 16'd5);
    chk1("link_before", link_up, 1'b0);
    tick();
    rx_trained = 1'b0;
    chkv("data_state", 16'(train_state), 16'd6);
    chk1("data_link", link_up, 1'b1);
    chk1("data_train", ctl_gb_train, 1'b0);
    chk1("data_zeros", ctl_gb_tx_zeros, 1'b0);

    // Scenario 4: train_failed at seq 20 in DATA
    wait_seq(7'd20);
    orx_otx_train_failed = 1'b1;
    tick();
    chkv("fail_state", 16'(train_state), 16'd1);
    chk1("fail_link", link_up, 1'b0);
    chkv("fail_seq", 16'(ctl_gb_seq), 16'd21);
    chk1("fail_zeros", ctl_gb_tx_zeros, 1'b1);
    wait_seq(7'd65);
    tick();
    chkv("fail_held_state", 16'(train_state), 16'd1);
    orx_otx_train_failed = 1'b0;
    cfg_timeout = 16'd3;
    wait_seq(7'd65);
    chkv("zeros_before_bnd", 16'(train_state), 16'd1);
    tick();
    chkv("pata_again", 16'(train_state), 16'd2);

    // Scenario 3: timeout after 3 boundaries in PAT_A
    wait_seq(7'd65);
    tick();
    chkv("to_b1_state", 16'(train_state), 16'd2);
    chk1("to_b1_pulse", train_timeout, 1'b0);
    wait_seq(7'd65);
    tick();
    chkv("to_b2_state", 16'(train_state), 16'd2);
    wait_seq(7'd65);
    chk1("to_pre_pulse", train_timeout, 1'b0);
    tick();
    chkv("to_state", 16'(train_state), 16'd1);
    chk1("to_pulse", train_timeout, 1'b1);
    tick();
    chk1("to_pulse_end", train_timeout, 1'b0);
    chkv("to_state_hold", 16'(train_state), 16'd1);
    cfg_timeout = 16'd0;

    // Scenario 6: rx_trained and train_failed together at a TRAIN boundary
    rx_pattern_a_det = 1'b1;
    rx_pattern_b_det = 1'b1;
    wait_state(3'd5);
    rx_pattern_a_det = 1'b0;
    rx_pattern_b_det = 1'b0;
    wait_seq(7'd65);
    rx_trained = 1'b1;
    orx_otx_train_failed = 1'b1;
    tick();
    chkv("both_state", 16'(train_state), 16'd1);
    chk1("both_link", link_up, 1'b0);
    rx_trained = 1'b0;
    orx_otx_train_failed = 1'b0;

    // Scenario 5: reset at seq 40 in TRAIN
    rx_pattern_a_det = 1'b1;
    rx_pattern_b_det = 1'b1;
    wait_state(3'd5);
    rx_pattern_a_det = 1'b0;
    rx_pattern_b_det = 1'b0;
    wait_seq(7'd64);
    chk1("train_stall64", ctl_gb_stall, 1'b1);
    wait_seq(7'd40);
    chk1("train_stall40", ctl_gb_stall, 1'b0);
    dlx_reset = 1'b1;
    tick();
    chkv("mid_rst_seq", 16'(ctl_gb_seq), 16'd0);
    chkv("mid_rst_state", 16'(train_state), 16'd0);
    chk1("mid_rst_stall", ctl_gb_stall, 1'b0);
    chk1("mid_rst_gbreset", ctl_gb_reset, 1'b1);
    chk1("mid_rst_train", ctl_gb_train, 1'b0);
    chk1("mid_rst_zeros", ctl_gb_tx_zeros, 1'b1);
    dlx_reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ocx_dlx_tx_gb_ctl.md
OCX_DLX_TX_GB_CTL -- requirements
Module: ocx_dlx_tx_gb_ctl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; every output SHALL be a flop output.
REQ-002 dlx_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 dlx_reset  in  1  synchronous, active-high reset.
REQ-004 phy_ready  in  1  PHY TX path ready; level input.
REQ-005 rx_pattern_a_det, rx_pattern_b_det, rx_trained  in  1 each  level status from the RX training logic.
REQ-006 orx_otx_train_failed  in  1  RX reports training failure; level input.
REQ-007 cfg_timeout  in  16  training timeout in frames; 0 = disabled.
REQ-008 ctl_gb_seq  out  7  gearbox sequence, 0..65.
REQ-009 ctl_gb_stall  out  1  TX queue hold.
REQ-010 ctl_gb_reset, ctl_gb_train, ctl_gb_tx_zeros, ctl_gb_tx_a_pattern, ctl_gb_tx_b_pattern, ctl_gb_tx_sync_pattern  out  1 each  gearbox mode controls.
REQ-011 link_up  out  1  DATA state reached.
REQ-012 train_state  out  3  current state encoding.
REQ-013 train_timeout  out  1  one-cycle pulse on timeout.

Function
REQ-014 Sequence counter: increments by 1 every cycle; wraps 65 -> 0. It runs in every state except RESET, where it holds at 0.
REQ-015 Stall: ctl_gb_stall SHALL be 1 whenever the counter is 64 or 65, which is gearbox step 32 (2 of every 66 cycles). This SHALL hold in every state except RESET.
REQ-016 Frame boundary: the cycle where the counter is 65.
REQ-017 State changes SHALL be committed only at a frame boundary, so no pattern block is torn.
REQ-018 Exceptions to REQ-017: dlx_reset and orx_otx_train_failed act on the next edge.
REQ-019 States and encodings: RESET=0, ZEROS=1, PAT_A=2, PAT_B=3, SYNC=4, TRAIN=5, DATA=6. Encoding 7 is unused and SHALL recover to RESET.
REQ-020 RESET: ctl_gb_reset=1 and ctl_gb_tx_zeros=1. Exits to ZEROS after exactly 2 cycles with dlx_reset low.
REQ-021 ZEROS: ctl_gb_tx_zeros=1; moves to PAT_A at the first frame boundary with phy_ready=1.
REQ-022 PAT_A: ctl_gb_tx_a_pattern=1; moves to PAT_B at a boundary with rx_pattern_a_det=1.
REQ-023 PAT_B: ctl_gb_tx_b_pattern=1; moves to SYNC at a boundary with rx_pattern_b_det=1.
REQ-024 SYNC: ctl_gb_tx_sync_pattern=1 for exactly one full frame (66 cycles), then TRAIN.
REQ-025 TRAIN: ctl_gb_train=1; moves to DATA at a boundary with rx_trained=1.
REQ-026 DATA: all mode controls 0; link_up=1.
REQ-027 Mode outputs: at most one of zeros/a/b/sync/train is 1 in any cycle; link_up=1 only in DATA.
REQ-028 Timeout counter: counts frame boundaries in PAT_A, PAT_B and TRAIN, and clears on every state change.
REQ-029 Timeout: when cfg_timeout != 0 and the count reaches cfg_timeout, the state goes to ZEROS and train_timeout pulses for 1 cycle.
REQ-030 The timeout counter saturates at 16 bits; it does not wrap.
REQ-031 orx_otx_train_failed=1 in any state except RESET: the next state is ZEROS, the counter keeps running, and the block stays in ZEROS while the input is 1.
REQ-032 Simultaneous events: dlx_reset > train_failed > timeout > normal advance.
REQ-033 If train_failed and a normal advance coincide at a boundary, failure wins.
REQ-034 A det input that deasserts before the boundary SHALL NOT advance the state (the input is sampled only at the boundary).

Reset
REQ-035 On dlx_reset: state=RESET, ctl_gb_seq=0, ctl_gb_stall=0, ctl_gb_reset=1, ctl_gb_tx_zeros=1.
REQ-036 Also on dlx_reset: all other mode outputs, link_up and train_timeout=0; timeout and SYNC counters=0.
REQ-037 Reset mid-frame or mid-training SHALL take effect on the next edge with no partial output.

Structure
REQ-038 A shared package SHALL hold: the state encodings, SEQ_LAST=65, STALL_FIRST=64, RESET_HOLD=2 and the SYNC frame length (1).
REQ-039 One sub-module: ocx_dlx_tx_gb_seq_cnt, which provides the sequence counter, stall and frame-boundary strobe. The FSM and timeout logic stay in the top module.

Verification
REQ-040 Scenario 1: release reset with phy_ready=1 -> ctl_gb_reset=1 for 2 cycles; ZEROS; then seq 0..65 repeating, with stall=1 exactly at seq 64 and 65.
REQ-041 Scenario 2: full bring-up with det inputs raised mid-frame -> state changes occur only on the cycle after seq=65; SYNC is high for exactly 66 cycles; link_up=1 afterwards.
REQ-042 Scenario 3: cfg_timeout=3 and rx_pattern_a_det held 0 -> after the 3rd boundary in PAT_A: train_timeout single pulse and state=ZEROS.
REQ-043 Scenario 4: orx_otx_train_failed pulsed at seq=20 while in DATA -> next cycle ZEROS with link_up=0; seq continues to 21.
REQ-044 Scenario 5: dlx_reset at seq=40 in TRAIN -> next cycle seq=0, RESET, stall=0.
REQ-045 Scenario 6: rx_trained and orx_otx_train_failed both 1 at a boundary in TRAIN -> ZEROS, not DATA.
